// File: rtl/spi_cmd_backend.sv
// Command/response engine between the SPI slave receive and transmit FIFOs.
// Decodes WRITE_REG / READ_REG / ECHO frames and pushes ACK/NAK/data responses.
module spi_cmd_backend #(
    parameter int                 DATA_W   = 8,
    parameter int                 NUM_REGS = 16,
    parameter int                 MAX_ECHO = 8,
    parameter logic [DATA_W-1:0]  ACK_CODE = 8'hA5,
    parameter logic [DATA_W-1:0]  NAK_CODE = 8'h5A
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       rd_empty,
    input  logic                       rd_ack,
    input  logic [DATA_W-1:0]          rd_buffer,
    output logic                       read,
    input  logic                       wr_full,
    input  logic                       wr_ack,
    output logic [DATA_W-1:0]          wr_buffer,
    output logic                       write,
    output logic [NUM_REGS*DATA_W-1:0] regs_out,
    output logic                       busy,
    output logic [7:0]                 err_count
);

    localparam int AW = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;
    localparam int EW = (MAX_ECHO > 1) ? $clog2(MAX_ECHO) : 1;

    localparam logic [7:0]        OP_WR   = 8'h01;
    localparam logic [7:0]        OP_RD   = 8'h02;
    localparam logic [7:0]        OP_ECHO = 8'h03;
    localparam logic [DATA_W:0]   LP_NUM_REGS = NUM_REGS[DATA_W:0];
    localparam logic [DATA_W-1:0] LP_MAX_ECHO = MAX_ECHO[DATA_W-1:0];
    localparam logic [DATA_W-1:0] IDX_ONE = 1;
    localparam logic [DATA_W:0]   RSP_ONE = 1;
    localparam logic [EW-1:0]     ECHO_ONE = 1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_ARGS,
        S_PAYLOAD,
        S_EXEC,
        S_RESPOND
    } state_t;

    state_t              r_state;
    state_t              w_next;
    logic                r_read;
    logic                r_write;
    logic [DATA_W-1:0]   r_wr_buffer;
    logic [7:0]          r_opcode;
    logic [1:0]          r_arg_cnt;
    logic [DATA_W-1:0]   r_addr;
    logic [DATA_W-1:0]   r_len;
    logic [DATA_W-1:0]   r_data;
    logic [DATA_W-1:0]   r_idx;
    logic [DATA_W:0]     r_rsp_idx;
    logic [DATA_W:0]     r_rsp_len;
    logic [DATA_W-1:0]   r_rsp0;
    logic [7:0]          r_err_count;
    logic [DATA_W-1:0]   r_regs [NUM_REGS];
    logic [DATA_W-1:0]   r_echo [MAX_ECHO];

    logic                w_pop;
    logic                w_push;
    logic                w_known;
    logic                w_last_arg;
    logic                w_last_pay;
    logic                w_rsp_last;
    logic                w_fetching;
    logic                w_rd_arm;
    logic                w_addr_ok;
    logic                w_nak;
    logic [DATA_W-1:0]   w_rsp0;
    logic [DATA_W:0]     w_rsp_len;
    logic [EW-1:0]       w_echo_idx;
    logic [DATA_W-1:0]   w_rsp_word;

    assign w_pop      = r_read & rd_ack;
    assign w_push     = r_write & wr_ack;
    assign w_known    = (rd_buffer[7:0] == OP_WR) || (rd_buffer[7:0] == OP_RD) ||
                        (rd_buffer[7:0] == OP_ECHO);
    assign w_last_arg = (r_arg_cnt == ((r_opcode == OP_WR) ? 2'd1 : 2'd0));
    assign w_last_pay = (r_idx == r_len - IDX_ONE);
    assign w_rsp_last = (r_rsp_idx == r_rsp_len - RSP_ONE);
    assign w_fetching = (r_state == S_IDLE) || (r_state == S_ARGS) || (r_state == S_PAYLOAD);
    // The final response ack also arms the next opcode pop so IDLE sees read already high.
    assign w_rd_arm   = !r_read && !rd_empty &&
                        (w_fetching || ((r_state == S_RESPOND) && w_push && w_rsp_last));
    assign w_addr_ok  = ({1'b0, r_addr} < LP_NUM_REGS);
    assign w_echo_idx = r_rsp_idx[EW-1:0] - ECHO_ONE;
    assign w_rsp_word = (r_rsp_idx == '0) ? r_rsp0 : r_echo[w_echo_idx];

    always_ff @(posedge clk) begin
        if (rst) r_state <= S_IDLE;
        else     r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        unique case (r_state)
            S_IDLE:    if (w_pop) w_next = w_known ? S_ARGS : S_EXEC;
            S_ARGS:    if (w_pop && w_last_arg)
                           w_next = ((r_opcode == OP_ECHO) && (rd_buffer != '0)) ? S_PAYLOAD : S_EXEC;
            S_PAYLOAD: if (w_pop && w_last_pay) w_next = S_EXEC;
            S_EXEC:    w_next = S_RESPOND;
            S_RESPOND: if (w_push && w_rsp_last) w_next = S_IDLE;
            default:   w_next = S_IDLE;
        endcase
    end

    // Response selection evaluated in EXEC against the current register file.
    always_comb begin
        w_nak     = 1'b1;
        w_rsp0    = NAK_CODE;
        w_rsp_len = RSP_ONE;
        unique case (r_opcode)
            OP_WR: begin
                w_nak  = !w_addr_ok;
                w_rsp0 = w_addr_ok ? ACK_CODE : NAK_CODE;
            end
            OP_RD: begin
                w_nak  = !w_addr_ok;
                w_rsp0 = w_addr_ok ? r_regs[r_addr[AW-1:0]] : NAK_CODE;
            end
            OP_ECHO: begin
                w_nak     = (r_len > LP_MAX_ECHO);
                w_rsp0    = w_nak ? NAK_CODE : ACK_CODE;
                w_rsp_len = w_nak ? RSP_ONE : ({1'b0, r_len} + RSP_ONE);
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_read      <= 1'b0;
            r_write     <= 1'b0;
            r_wr_buffer <= '0;
            r_opcode    <= '0;
            r_arg_cnt   <= '0;
            r_addr      <= '0;
            r_len       <= '0;
            r_data      <= '0;
            r_idx       <= '0;
            r_rsp_idx   <= '0;
            r_rsp_len   <= '0;
            r_rsp0      <= '0;
            r_err_count <= '0;
            for (int i = 0; i < NUM_REGS; i++) r_regs[i] <= '0;
        end else begin
            if (w_pop)         r_read <= 1'b0;
            else if (w_rd_arm) r_read <= 1'b1;

            unique case (r_state)
                S_IDLE: begin
                    if (w_pop) begin
                        r_opcode  <= rd_buffer[7:0];
                        r_arg_cnt <= '0;
                        r_idx     <= '0;
                    end
                end
                S_ARGS: begin
                    if (w_pop) begin
                        r_arg_cnt <= r_arg_cnt + 2'd1;
                        if (r_arg_cnt == 2'd0) begin
                            r_addr <= rd_buffer;
                            r_len  <= rd_buffer;
                        end else begin
                            r_data <= rd_buffer;
                        end
                    end
                end
                S_PAYLOAD: begin
                    if (w_pop) r_idx <= r_idx + IDX_ONE;
                end
                S_EXEC: begin
                    if ((r_opcode == OP_WR) && w_addr_ok) r_regs[r_addr[AW-1:0]] <= r_data;
                    if (w_nak && (r_err_count != 8'hFF)) r_err_count <= r_err_count + 8'd1;
                    r_rsp0    <= w_rsp0;
                    r_rsp_len <= w_rsp_len;
                    r_rsp_idx <= '0;
                    if (!wr_full) begin
                        r_write     <= 1'b1;
                        r_wr_buffer <= w_rsp0;
                    end
                end
                S_RESPOND: begin
                    if (w_push) begin
                        r_write   <= 1'b0;
                        r_rsp_idx <= r_rsp_idx + RSP_ONE;
                    end else if (!r_write && !wr_full) begin
                        r_write     <= 1'b1;
                        r_wr_buffer <= w_rsp_word;
                    end
                end
                default: ;
            endcase
        end
    end

    // Oversized echo payloads are drained without being stored.
    always_ff @(posedge clk) begin
        if ((r_state == S_PAYLOAD) && w_pop && (r_len <= LP_MAX_ECHO))
            r_echo[r_idx[EW-1:0]] <= rd_buffer;
    end

    for (genvar g = 0; g < NUM_REGS; g++) begin : g_regs_out
        assign regs_out[g*DATA_W +: DATA_W] = r_regs[g];
    end

    assign read      = r_read;
    assign write     = r_write;
    assign wr_buffer = r_wr_buffer;
    assign busy      = (r_state != S_IDLE);
    assign err_count = r_err_count;

endmodule

// File: tb/tb_spi_cmd_backend.sv
// Directed bench for spi_cmd_backend: drives the FIFO handshakes from the negedge
// and checks every response word, handshake level and register value by assertion.
module tb_spi_cmd_backend;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         rd_empty = 1'b1;
    logic         rd_ack = 1'b0;
    logic [7:0]   rd_buffer = '0;
    logic         read;
    logic         wr_full = 1'b0;
    logic         wr_ack = 1'b0;
    logic [7:0]   wr_buffer;
    logic         write;
    logic [127:0] regs_out;
    logic         busy;
    logic [7:0]   err_count;

    int vecs  = 0;
    int fails = 0;

    spi_cmd_backend #(
        .DATA_W  (8),
        .NUM_REGS(16),
        .MAX_ECHO(8),
        .ACK_CODE(8'hA5),
        .NAK_CODE(8'h5A)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .rd_empty (rd_empty),
        .rd_ack   (rd_ack),
        .rd_buffer(rd_buffer),
        .read     (read),
        .wr_full  (wr_full),
        .wr_ack   (wr_ack),
        .wr_buffer(wr_buffer),
        .write    (write),
        .regs_out (regs_out),
        .busy     (busy),
        .err_count(err_count)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: observed no finish, expected finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        vecs++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic send_word(input logic [7:0] w, input int stall);
        int n;
        rd_empty = 1'b0;
        n = 0;
        while (!read && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (!read) begin
            chk("rd_timeout", read, 1);
            return;
        end
        if (stall > 0) begin
            rd_empty = 1'b1;
            repeat (stall) begin
                @(negedge clk);
                chk("rd_hold", read, 1);
            end
        end
        rd_ack    = 1'b1;
        rd_buffer = w;
        @(negedge clk);
        rd_ack    = 1'b0;
        rd_empty  = 1'b1;
        chk("rd_drop", read, 0);
    endtask

    task automatic recv_word(input logic [7:0] exp, input int full_cyc, input int hold);
        int n;
        if (full_cyc > 0) begin
            wr_full = 1'b1;
            repeat (full_cyc) begin
                @(negedge clk);
                chk("wr_backpressure", write, 0);
            end
            wr_full = 1'b0;
        end
        n = 0;
        while (!write && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (!write) begin
            chk("wr_timeout", write, 1);
            return;
        end
        chk("wr_data", wr_buffer, exp);
        repeat (hold) begin
            @(negedge clk);
            chk("wr_keep", write, 1);
            chk("wr_stable", wr_buffer, exp);
        end
        wr_ack = 1'b1;
        @(negedge clk);
        wr_ack = 1'b0;
        chk("wr_drop", write, 0);
    endtask

    initial begin
        // Reset with data available; read must stay low until reset is released.
        rd_empty = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst_read", read, 0);
        chk("rst_write", write, 0);
        chk("rst_regs", regs_out, 0);
        chk("rst_err", err_count, 0);
        chk("rst_busy", busy, 0);
        rst = 1'b0;
        @(negedge clk);
        chk("rst_read_rise", read, 1);

        // WRITE_REG 3 <= 3C, first response two cycles after the data ack.
        send_word(8'h01, 0);
        send_word(8'h03, 0);
        send_word(8'h3C, 0);
        chk("exec_busy", busy, 1);
        chk("exec_reg3_old", regs_out[3*8 +: 8], 8'h00);
        @(negedge clk);
        chk("wr_reg3", regs_out[3*8 +: 8], 8'h3C);
        chk("first_write_lat", write, 1);
        recv_word(8'hA5, 0, 0);
        chk("wr_busy_end", busy, 0);

        // READ_REG 3, with an opcode pending so read re-arms on the final ack.
        send_word(8'h02, 0);
        send_word(8'h03, 0);
        rd_empty = 1'b0;
        recv_word(8'h3C, 0, 0);
        chk("rd_busy_end", busy, 0);
        chk("rd_rearm", read, 1);
        rd_empty = 1'b1;

        // ECHO of four words under transmit backpressure.
        send_word(8'h03, 0);
        send_word(8'h04, 0);
        send_word(8'h11, 0);
        send_word(8'h22, 0);
        send_word(8'h33, 0);
        send_word(8'h44, 0);
        recv_word(8'hA5, 2, 1);
        recv_word(8'h11, 0, 2);
        recv_word(8'h22, 3, 0);
        recv_word(8'h33, 1, 1);
        recv_word(8'h44, 0, 0);
        chk("echo_busy_end", busy, 0);

        // Error frames: bad address, unknown opcode, oversized echo.
        send_word(8'h02, 0);
        send_word(8'h10, 0);
        recv_word(8'h5A, 0, 0);
        send_word(8'h7F, 0);
        recv_word(8'h5A, 0, 0);
        send_word(8'h03, 0);
        send_word(8'h09, 0);
        for (int i = 1; i <= 9; i++) send_word(8'(i), 0);
        recv_word(8'h5A, 0, 0);
        chk("err_count3", err_count, 3);
        chk("err_busy_end", busy, 0);
        send_word(8'h02, 0);
        send_word(8'h00, 0);
        recv_word(8'h00, 0, 0);
        chk("err_reg3_kept", regs_out[3*8 +: 8], 8'h3C);

        // ECHO with zero length answers ACK only.
        send_word(8'h03, 0);
        send_word(8'h00, 0);
        recv_word(8'hA5, 0, 0);
        chk("echo0_busy_end", busy, 0);

        // Receive stalls: empty FIFO between args, then a slow ack.
        send_word(8'h01, 0);
        send_word(8'h05, 0);
        repeat (4) begin
            @(negedge clk);
            chk("rd_idle_empty", read, 0);
        end
        send_word(8'h77, 5);
        recv_word(8'hA5, 0, 0);
        send_word(8'h02, 0);
        send_word(8'h05, 0);
        recv_word(8'h77, 0, 0);
        chk("stall_err_count", err_count, 3);

        // Reset in the middle of an echo payload.
        send_word(8'h03, 0);
        send_word(8'h03, 0);
        send_word(8'hAA, 0);
        chk("mid_busy", busy, 1);
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        chk("mid_read", read, 0);
        chk("mid_write", write, 0);
        chk("mid_wrbuf", wr_buffer, 0);
        chk("mid_busy_rst", busy, 0);
        chk("mid_regs", regs_out, 0);
        chk("mid_err", err_count, 0);
        send_word(8'h02, 0);
        send_word(8'h00, 0);
        recv_word(8'h00, 0, 0);
        chk("mid_busy_end", busy, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vecs, fails);
        $finish;
    end

endmodule
